// File: rtl/seq_div8.sv
// seq_div8: multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for signed two's-complement division; undefined gives unsigned division.
module seq_div8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] QUO,
  output logic [WIDTH-1:0] REM,
  output logic             OV,
  output logic             DVZ
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  // state | meaning
  // IDLE  | waiting for start, results held
  // DIV   | one restoring step per clock
  // FIX   | sign fix-up, register results, pulse done
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] a_raw;
  logic             b_zero;
`ifdef DIV_SIGNED_EN
  logic             b_neg;
`endif

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             ov_fix;

  always_comb begin
`ifdef DIV_SIGNED_EN
    a_mag = A[WIDTH-1] ? -A : A;
    b_mag = B[WIDTH-1] ? -B : B;
`else
    a_mag = A;
    b_mag = B;
`endif
    shifted = {rem, dvd[WIDTH-1]};
    trial   = shifted - {1'b0, dsr};
  end

  always_comb begin
`ifdef DIV_SIGNED_EN
    q_fix  = (a_raw[WIDTH-1] ^ b_neg) ? -dvd : dvd;
    r_fix  = a_raw[WIDTH-1] ? -rem : rem;
    // Only |most-negative| / 1 with like signs leaves bit WIDTH-1 set on a positive result
    ov_fix = ~(a_raw[WIDTH-1] ^ b_neg) & dvd[WIDTH-1];
`else
    q_fix  = dvd;
    r_fix  = rem;
    ov_fix = 1'b0;
`endif
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      dvd    <= '0;
      dsr    <= '0;
      a_raw  <= '0;
      b_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      b_neg  <= 1'b0;
`endif
      done   <= 1'b0;
      QUO    <= '0;
      REM    <= '0;
      OV     <= 1'b0;
      DVZ    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_raw  <= A;
            b_zero <= (B == '0);
`ifdef DIV_SIGNED_EN
            b_neg  <= B[WIDTH-1];
`endif
            dvd    <= a_mag;
            dsr    <= b_mag;
            rem    <= '0;
            cnt    <= '0;
            state  <= DIV;
          end
        end
        DIV: begin
          if (trial[WIDTH]) rem <= shifted[WIDTH-1:0];
          else              rem <= trial[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= FIX;
        end
        FIX: begin
          done  <= 1'b1;
          state <= IDLE;
          if (b_zero) begin
            QUO <= '0;
            REM <= a_raw;
            OV  <= 1'b0;
            DVZ <= 1'b1;
          end else begin
            QUO <= q_fix;
            REM <= r_fix;
            OV  <= ov_fix;
            DVZ <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div8.sv
// tb_seq_div8: table-driven check of seq_div8 results and latency, plus handshake and reset sequences.
// Expected values follow DIV_SIGNED_EN the same way the design does.
module tb_seq_div8;
  localparam int W = 8;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst, start;
  logic [W-1:0] a, b;
  logic busy, done, ov, dvz;
  logic [W-1:0] quo, rem;

  int tests = 0;
  int fails = 0;

  seq_div8 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .QUO(quo), .REM(rem), .OV(ov), .DVZ(dvz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ov;
    logic         dz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic o, output logic z, output int lat);
    @(negedge clk);
    a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 3 * LAT; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    q = quo; r = rem; o = ov; z = dvz;
  endtask

  initial begin
    logic [W-1:0] q, r;
    logic o, z;
    int lat, ndone, first;

`ifdef DIV_SIGNED_EN
    vecs[0] = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};
    vecs[2] = '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h7F, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h05, 8'h00, 8'h00, 8'h05, 1'b0, 1'b1};
    vecs[6] = '{8'hC8, 8'h03, 8'hEE, 8'hFE, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[8] = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
`else
    vecs[0] = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h9C, 8'h07, 8'h16, 8'h02, 1'b0, 1'b0};
    vecs[2] = '{8'h64, 8'hF9, 8'h00, 8'h64, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h05, 8'h00, 8'h00, 8'h05, 1'b0, 1'b1};
    vecs[6] = '{8'hC8, 8'h03, 8'h42, 8'h02, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[8] = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
`endif

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quo", quo, 0);
    chk("reset_rem", rem, 0);
    chk("reset_ov", ov, 0);
    chk("reset_dvz", dvz, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Back-to-back at minimum spacing: each run_op starts in the previous done cycle
    foreach (vecs[k]) begin
      run_op(vecs[k].a, vecs[k].b, q, r, o, z, lat);
      chk($sformatf("v%0d_latency", k), lat, LAT);
      chk($sformatf("v%0d_quo", k), q, vecs[k].q);
      chk($sformatf("v%0d_rem", k), r, vecs[k].r);
      chk($sformatf("v%0d_ov", k), o, vecs[k].ov);
      chk($sformatf("v%0d_dvz", k), z, vecs[k].dz);
      chk($sformatf("v%0d_busy_at_done", k), busy, 0);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("quo_held", quo, 8'h00);

    // Start re-pulsed 3 cycles into an operation must be ignored
    @(negedge clk);
    a = 8'h64; b = 8'h07; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first = -1;
    for (int i = 1; i <= 3 * LAT; i++) begin
      if (i == 4) begin
        @(negedge clk);
        a = 8'h11; b = 8'h01; start = 1'b1;
      end
      @(posedge clk); #1;
      if (i == 4) start = 1'b0;
      if (i < LAT) chk($sformatf("busy_edge%0d", i), busy, 1);
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = i;
          chk("hs_quo", quo, 8'h0E);
          chk("hs_rem", rem, 8'h02);
        end
      end
    end
    chk("hs_latency", first, LAT);
    chk("hs_done_count", ndone, 1);

    // Reset 4 cycles into an operation aborts it
    @(negedge clk);
    a = 8'h64; b = 8'h07; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quo", quo, 0);
    chk("abort_rem", rem, 0);
    chk("abort_ov", ov, 0);
    chk("abort_dvz", dvz, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op(8'h7F, 8'h7F, q, r, o, z, lat);
    chk("post_reset_latency", lat, LAT);
    chk("post_reset_quo", q, 8'h01);
    chk("post_reset_rem", r, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
